// File: rtl/nf10_axis_pkt_gen.sv
// AXI-Stream packet generator: on start, emits num_pkts packets of pkt_len bytes
// whose payload is the running byte index, with length/source/index metadata on tuser.
`timescale 1ns/1ps
module nf10_axis_pkt_gen #(
  parameter int unsigned C_M_AXIS_DATA_WIDTH  = 256,
  parameter int unsigned C_M_AXIS_TUSER_WIDTH = 128
) (
  input  logic                              aclk,
  input  logic                              aresetn,
  input  logic                              start,
  input  logic [15:0]                       pkt_len,
  input  logic [7:0]                        num_pkts,
  input  logic [7:0]                        src_port,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tlast,
  output logic                              busy,
  output logic [7:0]                        counter,
  output logic                              activity_send
);

  localparam int unsigned BYTES  = C_M_AXIS_DATA_WIDTH / 8;
  localparam int unsigned BEAT_W = 12;

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_e;

  state_e                            state_q, state_d;
  logic [15:0]                       len_q, len_d;
  logic [7:0]                        npkts_q, npkts_d;
  logic [7:0]                        src_q, src_d;
  logic [BEAT_W-1:0]                 beat_q, beat_d;
  logic [7:0]                        pkt_idx_q, pkt_idx_d;
  logic [7:0]                        counter_q, counter_d;
  logic                              act_q, act_d;
  logic [C_M_AXIS_DATA_WIDTH-1:0]    tdata_q, tdata_d;
  logic [BYTES-1:0]                  tstrb_q, tstrb_d;
  logic [C_M_AXIS_TUSER_WIDTH-1:0]   tuser_q, tuser_d;
  logic                              tlast_q, tlast_d;

  logic                              xfer;
  logic                              last_beat;
  logic [BEAT_W-1:0]                 nbeats;
  int unsigned                       rem;

  // State register and registered beat payload.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= IDLE;
      len_q     <= '0;
      npkts_q   <= '0;
      src_q     <= '0;
      beat_q    <= '0;
      pkt_idx_q <= '0;
      counter_q <= '0;
      act_q     <= 1'b0;
      tdata_q   <= '0;
      tstrb_q   <= '0;
      tuser_q   <= '0;
      tlast_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      npkts_q   <= npkts_d;
      src_q     <= src_d;
      beat_q    <= beat_d;
      pkt_idx_q <= pkt_idx_d;
      counter_q <= counter_d;
      act_q     <= act_d;
      tdata_q   <= tdata_d;
      tstrb_q   <= tstrb_d;
      tuser_q   <= tuser_d;
      tlast_q   <= tlast_d;
    end
  end

  // Next-state logic; the payload is built from the next beat position so it is
  // already registered when that beat is presented.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    npkts_d   = npkts_q;
    src_d     = src_q;
    beat_d    = beat_q;
    pkt_idx_d = pkt_idx_q;
    counter_d = counter_q;
    act_d     = 1'b0;
    tdata_d   = '0;
    tstrb_d   = '0;
    tuser_d   = '0;
    tlast_d   = 1'b0;
    xfer      = m_axis_tvalid && m_axis_tready;

    case (state_q)
      IDLE: begin
        if (start && (pkt_len != 16'd0) && (num_pkts != 8'd0)) begin
          state_d   = SEND;
          len_d     = pkt_len;
          npkts_d   = num_pkts;
          src_d     = src_port;
          beat_d    = '0;
          pkt_idx_d = '0;
        end
      end
      SEND: begin
        if (xfer) begin
          if (tlast_q) begin
            counter_d = counter_q + 8'd1;
            act_d     = 1'b1;
            beat_d    = '0;
            if (pkt_idx_q == npkts_q - 8'd1) begin
              state_d = IDLE;
            end else begin
              pkt_idx_d = pkt_idx_q + 8'd1;
            end
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    nbeats    = BEAT_W'((32'(len_d) + BYTES - 1) / BYTES);
    rem       = 32'(len_d) % BYTES;
    last_beat = (beat_d == nbeats - BEAT_W'(1));

    if (state_d == SEND) begin
      tlast_d        = last_beat;
      tuser_d[15:0]  = len_d;
      tuser_d[23:16] = src_d;
      tuser_d[39:32] = pkt_idx_d;
      for (int unsigned j = 0; j < BYTES; j++) begin
        if (!last_beat || (rem == 0) || (j < rem)) begin
          tstrb_d[j]         = 1'b1;
          tdata_d[8*j +: 8]  = 8'(32'(beat_d) * BYTES + j);
        end
      end
    end
  end

  assign m_axis_tvalid = (state_q == SEND);
  assign busy          = (state_q == SEND);
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tstrb  = tstrb_q;
  assign m_axis_tuser  = tuser_q;
  assign m_axis_tlast  = tlast_q;
  assign counter       = counter_q;
  assign activity_send = act_q;

endmodule

// File: tb/tb_nf10_axis_pkt_gen.sv
// Directed bench for nf10_axis_pkt_gen: table of bursts plus hand sequences for
// ignored starts, backpressure, mid-burst reset and counter wrap.
`timescale 1ns/1ps
module tb_nf10_axis_pkt_gen;

  localparam int unsigned DW = 256;
  localparam int unsigned UW = 128;
  localparam int unsigned B  = 32;

  logic              aclk = 1'b0;
  logic              aresetn;
  logic              start;
  logic [15:0]       pkt_len;
  logic [7:0]        num_pkts;
  logic [7:0]        src_port;
  logic [DW-1:0]     m_axis_tdata;
  logic [DW/8-1:0]   m_axis_tstrb;
  logic [UW-1:0]     m_axis_tuser;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic              m_axis_tlast;
  logic              busy;
  logic [7:0]        counter;
  logic              activity_send;

  nf10_axis_pkt_gen #(
    .C_M_AXIS_DATA_WIDTH (DW),
    .C_M_AXIS_TUSER_WIDTH(UW)
  ) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .start        (start),
    .pkt_len      (pkt_len),
    .num_pkts     (num_pkts),
    .src_port     (src_port),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tstrb (m_axis_tstrb),
    .m_axis_tuser (m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast),
    .busy         (busy),
    .counter      (counter),
    .activity_send(activity_send)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [15:0] len;
    logic [7:0]  n;
    logic [7:0]  src;
    int          total;      // expected beats in the whole burst
    logic [31:0] last_strb;  // expected tstrb on each packet's last beat
    int          stall_at;   // burst beat held with tready=0 for 2 cycles (-1: none)
  } vec_t;

  localparam int NV = 7;
  vec_t vecs [NV];

  int          n_vec = 0;
  int          n_bad = 0;
  logic [7:0]  exp_cnt = 8'd0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] exp_data(input int len, input int b);
    logic [255:0] d = '0;
    for (int j = 0; j < 32; j++) begin
      int idx = b * 32 + j;
      if (idx < len) d[8*j +: 8] = 8'(idx);
    end
    return d;
  endfunction

  function automatic logic [31:0] exp_strb(input int len, input int b);
    logic [31:0] s = '0;
    for (int j = 0; j < 32; j++) if (b * 32 + j < len) s[j] = 1'b1;
    return s;
  endfunction

  function automatic logic [127:0] exp_user(input logic [15:0] len, input logic [7:0] src,
                                            input int pkt);
    logic [127:0] u = '0;
    u[15:0]  = len;
    u[23:16] = src;
    u[39:32] = 8'(pkt);
    return u;
  endfunction

  // Runs one burst starting and ending on a falling edge.
  task automatic run_burst(input vec_t v);
    int nb = (int'(v.len) + 31) / 32;
    int got = 0, pkt = 0, b = 0, acts = 0, cyc = 0, stalls = 0;
    logic held = 1'b0;
    logic [255:0] hd;
    logic [127:0] hu;
    logic hl;
    pkt_len = v.len; num_pkts = v.n; src_port = v.src; start = 1'b1; m_axis_tready = 1'b1;
    @(negedge aclk);
    start = 1'b0;
    while (got < v.total && cyc < 5000) begin
      if (activity_send) acts++;
      check("tvalid_in_burst", m_axis_tvalid, 1);
      check("busy_in_burst", busy, 1);
      if (held) begin
        check("hold_tdata", m_axis_tdata, hd);
        check("hold_tuser", m_axis_tuser, hu);
        check("hold_tlast", m_axis_tlast, hl);
      end
      if (got == v.stall_at && stalls < 2) begin
        m_axis_tready = 1'b0;
        stalls++;
        held = 1'b1;
        hd = m_axis_tdata; hu = m_axis_tuser; hl = m_axis_tlast;
      end else begin
        m_axis_tready = 1'b1;
        held = 1'b0;
        check("tdata", m_axis_tdata, exp_data(int'(v.len), b));
        check("tstrb", m_axis_tstrb, exp_strb(int'(v.len), b));
        check("tuser", m_axis_tuser, exp_user(v.len, v.src, pkt));
        check("tlast", m_axis_tlast, (b == nb - 1));
        if (b == nb - 1) begin
          check("last_tstrb", m_axis_tstrb, v.last_strb);
          b = 0;
          pkt++;
        end else begin
          b++;
        end
        got++;
      end
      @(negedge aclk);
      cyc++;
    end
    m_axis_tready = 1'b1;
    exp_cnt = exp_cnt + v.n;
    check("beat_total", got, v.total);
    if (activity_send) acts++;
    check("activity_pulses", acts, v.n);
    check("tvalid_after_burst", m_axis_tvalid, 0);
    check("busy_after_burst", busy, 0);
    check("counter", counter, exp_cnt);
    @(negedge aclk);
    check("activity_one_cycle", activity_send, 0);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_tvalid"}, m_axis_tvalid, 0);
    check({tag, "_tlast"},  m_axis_tlast, 0);
    check({tag, "_tdata"},  m_axis_tdata, 0);
    check({tag, "_tstrb"},  m_axis_tstrb, 0);
    check({tag, "_tuser"},  m_axis_tuser, 0);
    check({tag, "_busy"},   busy, 0);
    check({tag, "_counter"}, counter, 0);
    check({tag, "_activity"}, activity_send, 0);
  endtask

  task automatic do_reset();
    @(negedge aclk);
    aresetn = 1'b0;
    #1;
    reset_checks("rst");
    exp_cnt = 8'd0;
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
  endtask

  initial begin
    int beats, cyc;
    start = 1'b0; pkt_len = '0; num_pkts = '0; src_port = '0;
    m_axis_tready = 1'b1; aresetn = 1'b0;

    vecs[0] = '{16'd64,  8'd1, 8'h01, 2,  32'hFFFF_FFFF, -1};
    vecs[1] = '{16'd60,  8'd1, 8'h02, 2,  32'h0FFF_FFFF, -1};
    vecs[2] = '{16'd33,  8'd3, 8'h03, 6,  32'h0000_0001, -1};
    vecs[3] = '{16'd1,   8'd1, 8'hAA, 1,  32'h0000_0001, -1};
    vecs[4] = '{16'd32,  8'd2, 8'h55, 2,  32'hFFFF_FFFF, -1};
    vecs[5] = '{16'd64,  8'd1, 8'h07, 2,  32'hFFFF_FFFF, 0};
    vecs[6] = '{16'd300, 8'd2, 8'h10, 20, 32'h0000_0FFF, 13};

    #12;
    reset_checks("init");
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);

    // Starts with a zero length or zero count are ignored.
    pkt_len = 16'd0; num_pkts = 8'd1; start = 1'b1;
    @(negedge aclk); start = 1'b0;
    check("zero_len_busy", busy, 0);
    check("zero_len_tvalid", m_axis_tvalid, 0);
    pkt_len = 16'd8; num_pkts = 8'd0; start = 1'b1;
    @(negedge aclk); start = 1'b0;
    check("zero_n_busy", busy, 0);
    check("zero_n_tvalid", m_axis_tvalid, 0);

    for (int i = 0; i < NV; i++) run_burst(vecs[i]);

    // A start arriving while busy must neither relatch nor queue a burst.
    m_axis_tready = 1'b0; pkt_len = 16'd64; num_pkts = 8'd1; src_port = 8'h01; start = 1'b1;
    @(negedge aclk); start = 1'b0;
    check("busy_start_tvalid", m_axis_tvalid, 1);
    pkt_len = 16'd200; num_pkts = 8'd5; src_port = 8'hEE; start = 1'b1;
    @(negedge aclk); start = 1'b0;
    check("busy_start_len", m_axis_tuser[15:0], 16'd64);
    check("busy_start_src", m_axis_tuser[23:16], 8'h01);
    m_axis_tready = 1'b1;
    beats = 0; cyc = 0;
    while (m_axis_tvalid && cyc < 100) begin
      beats++;
      @(negedge aclk);
      cyc++;
    end
    exp_cnt = exp_cnt + 8'd1;
    check("busy_start_beats", beats, 2);
    @(negedge aclk);
    check("busy_start_no_queue", busy, 0);
    check("busy_start_counter", counter, exp_cnt);

    // Reset during beat 2 of 4 aborts the burst immediately.
    pkt_len = 16'd128; num_pkts = 8'd1; src_port = 8'h33; start = 1'b1;
    @(negedge aclk); start = 1'b0;
    @(negedge aclk);
    check("mid_beat2_data", m_axis_tdata, exp_data(128, 1));
    aresetn = 1'b0;
    #1;
    reset_checks("midrst");
    exp_cnt = 8'd0;
    @(negedge aclk);
    aresetn = 1'b1;
    repeat (3) @(negedge aclk);
    check("post_rst_idle", m_axis_tvalid, 0);
    run_burst('{16'd128, 8'd1, 8'h33, 4, 32'hFFFF_FFFF, -1});

    // Counter wraps 255 -> 0.
    do_reset();
    run_burst('{16'd1, 8'd255, 8'h5A, 255, 32'h0000_0001, -1});
    run_burst('{16'd1, 8'd1,   8'h5A, 1,   32'h0000_0001, -1});
    check("counter_wrapped", counter, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/nf10_axis_pkt_gen.md
NF10_AXIS_PKT_GEN -- requirements
Module: nf10_axis_pkt_gen

Interface
REQ-001 SHALL have parameter C_M_AXIS_DATA_WIDTH, default 256: tdata width in bits, a multiple of 8.
REQ-002 SHALL have parameter C_M_AXIS_TUSER_WIDTH, default 128: tuser width in bits, at least 48.
REQ-003 SHALL have port aclk  input  1: single clock; all logic is rising-edge.
REQ-004 SHALL have port aresetn  input  1: reset, asynchronous and active-low.
REQ-005 SHALL have port start  input  1: one-cycle request to begin a burst.
REQ-006 SHALL have port pkt_len  input  16: packet length in bytes, sampled on start.
REQ-007 SHALL have port num_pkts  input  8: packets per burst, sampled on start.
REQ-008 SHALL have port src_port  input  8: source-port code, sampled on start.
REQ-009 SHALL have port m_axis_tdata  output  C_M_AXIS_DATA_WIDTH: stream data.
REQ-010 SHALL have port m_axis_tstrb  output  C_M_AXIS_DATA_WIDTH/8: byte-valid mask.
REQ-011 SHALL have port m_axis_tuser  output  C_M_AXIS_TUSER_WIDTH: packet metadata.
REQ-012 SHALL have port m_axis_tvalid  output  1: beat valid.
REQ-013 SHALL have port m_axis_tready  input  1: downstream accept.
REQ-014 SHALL have port m_axis_tlast  output  1: last beat of packet.
REQ-015 SHALL have port busy  output  1: burst in progress.
REQ-016 SHALL have port counter  output  8: packets completed since reset.
REQ-017 SHALL have port activity_send  output  1: one-cycle pulse per completed packet.

Function
REQ-018 SHALL implement a two-state FSM: IDLE and SEND.
REQ-019 IDLE->SEND SHALL occur on start=1 with pkt_len!=0 and num_pkts!=0; pkt_len, num_pkts and src_port are latched on that edge.
REQ-020 start SHALL be ignored in SEND, and in IDLE when either pkt_len or num_pkts is zero.
REQ-021 tvalid SHALL rise the cycle after the accepting start edge, and SHALL stay 1 through every beat of the burst with no idle cycles between packets.
REQ-022 A beat SHALL transfer only when tvalid=1 and tready=1; while tvalid=1 and tready=0, tdata, tstrb, tuser and tlast SHALL hold stable.
REQ-023 Beats per packet SHALL be ceil(pkt_len/B), where B = C_M_AXIS_DATA_WIDTH/8.
REQ-024 Byte j of beat b SHALL equal (b*B+j) mod 256, i.e. the byte index within the packet, truncated to 8 bits.
REQ-025 tstrb SHALL be all-ones on every non-last beat; on the last beat its low (pkt_len mod B) bits SHALL be set, or all bits if that value is 0; tdata bytes whose tstrb bit is clear SHALL be 0.
REQ-026 tuser SHALL be constant within a packet: [15:0]=pkt_len, [23:16]=src_port, [31:24]=0, [39:32]=packet index within the burst (0-based), [47:40]=0, upper bits 0.
REQ-027 tlast SHALL be 1 only on the final beat of each packet.
REQ-028 On acceptance of a tlast beat: counter SHALL increment modulo 256 (255->0), and activity_send SHALL pulse high for exactly the next cycle.
REQ-029 After the tlast beat of packet num_pkts-1 is accepted, the FSM SHALL return to IDLE, with tvalid=0 and busy=0 in the next cycle.
REQ-030 busy SHALL be 1 exactly while the FSM is in SEND.
REQ-031 The beat counter SHALL be 12 bits wide, so that 65535 bytes (2048 beats at B=32) does not overflow.

Reset
REQ-032 While aresetn=0, all of the following SHALL be 0 asynchronously: tvalid, tlast, tdata, tstrb, tuser, busy, counter, activity_send; the FSM SHALL be in IDLE.
REQ-033 Reset asserted mid-packet SHALL abort the burst with no further beats; after release, the block SHALL wait for a new start.

Verification
REQ-034 pkt_len=64, num_pkts=1, src_port=0x01, tready=1 -> 2 beats; beat1 byte0=0x00 and byte31=0x1F; beat2 byte0=0x20, tlast=1; tuser[15:0]=0x0040; counter=1.
REQ-035 pkt_len=60, B=32 -> beat2 tstrb=0x0FFFFFFF and bytes 28..31 = 0.
REQ-036 num_pkts=3, pkt_len=33, tready=1 -> 6 consecutive valid beats; tuser[39:32] = 0,1,2 per packet; activity_send pulses 3 times; busy falls after the 6th beat.
REQ-037 tready toggles 1,0,0,1 during beat 1 -> tdata/tuser/tlast stay stable while tready=0; total beat count unchanged.
REQ-038 aresetn=0 during beat 2 of 4 -> tvalid=0 immediately, counter=0; a new start after release sends a complete, correct packet.
REQ-039 start while busy, or start with pkt_len=0 -> no effect; 256 completed packets -> counter wraps to 0.
